// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, ownership helpers and controller states.
package chess_pkg;

    localparam logic [3:0] EMPTY    = 4'h0;
    localparam logic [3:0] W_PAWN   = 4'h1;
    localparam logic [3:0] W_KNIGHT = 4'h2;
    localparam logic [3:0] W_BISHOP = 4'h3;
    localparam logic [3:0] W_ROOK   = 4'h4;
    localparam logic [3:0] W_QUEEN  = 4'h5;
    localparam logic [3:0] W_KING   = 4'h6;
    localparam logic [3:0] B_PAWN   = 4'h7;
    localparam logic [3:0] B_KNIGHT = 4'h8;
    localparam logic [3:0] B_BISHOP = 4'h9;
    localparam logic [3:0] B_ROOK   = 4'hA;
    localparam logic [3:0] B_QUEEN  = 4'hB;
    localparam logic [3:0] B_KING   = 4'hC;
    localparam logic [3:0] HL       = 4'hD;

    typedef enum logic [2:0] {
        SELECT = 3'd0,
        GEN    = 3'd1,
        PICK   = 3'd2,
        HOLD   = 3'd3,
        SETTLE = 3'd4,
        OVER   = 3'd5
    } mc_state_t;

    function automatic logic is_white(input logic [3:0] code);
        return (code >= W_PAWN) && (code <= W_KING);
    endfunction

    function automatic logic is_black(input logic [3:0] code);
        return (code >= B_PAWN) && (code <= B_KING);
    endfunction

endpackage

// File: rtl/move_controller.sv
// Turn/move sequencer: turns validated clicks into pick/place pulses, gates on
// side-to-move and the legal-move mask, and freezes once a win is reported.
module move_controller
    import chess_pkg::*;
#(
    parameter int GEN_TIMEOUT = 255,
    parameter int CNT_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             click,
    input  logic [5:0]       mouse_sq,
    input  logic [3:0]       sq_code,
    input  logic [63:0]      possible_moves,
    input  logic             gen_done,
    input  logic             white_win,
    input  logic             black_win,
    output logic             gen_start,
    output logic [5:0]       sel_sq,
    output logic             pick_piece,
    output logic             place_piece,
    output logic [5:0]       figure_position,
    output logic [63:0]      hl_moves,
    output logic             turn,
    output logic             holding,
    output logic             game_over,
    output logic [CNT_W-1:0] half_moves
);

    localparam int            TW    = (GEN_TIMEOUT > 1) ? $clog2(GEN_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(GEN_TIMEOUT - 1);

    mc_state_t     state;
    logic [63:0]   moves_q;
    logic [TW-1:0] timer;
    logic          own_piece;

    assign own_piece = turn ? is_black(sq_code) : is_white(sq_code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= SELECT;
            moves_q         <= '0;
            timer           <= '0;
            sel_sq          <= '0;
            gen_start       <= 1'b0;
            pick_piece      <= 1'b0;
            place_piece     <= 1'b0;
            figure_position <= '0;
            hl_moves        <= '0;
            turn            <= 1'b0;
            holding         <= 1'b0;
            game_over       <= 1'b0;
            half_moves      <= '0;
        end else begin
            gen_start   <= 1'b0;
            pick_piece  <= 1'b0;
            place_piece <= 1'b0;
            case (state)
                SELECT: begin
                    if (click && own_piece) begin
                        sel_sq    <= mouse_sq;
                        gen_start <= 1'b1;
                        timer     <= '0;
                        state     <= GEN;
                    end
                end
                GEN: begin
                    // gen_done takes priority over an expiring timeout
                    if (gen_done) begin
                        moves_q <= possible_moves;
                        if (possible_moves == '0) begin
                            state <= SELECT;
                        end else begin
                            pick_piece      <= 1'b1;
                            figure_position <= sel_sq;
                            state           <= PICK;
                        end
                    end else if (timer == TLAST) begin
                        state <= SELECT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PICK: begin
                    holding  <= 1'b1;
                    hl_moves <= moves_q;
                    state    <= HOLD;
                end
                HOLD: begin
                    // Stay one extra cycle while place_piece is high so SETTLE
                    // sees the win flags the board updates at the end of it.
                    if (place_piece) begin
                        state <= SETTLE;
                    end else if (click && (moves_q[mouse_sq] || mouse_sq == sel_sq)) begin
                        place_piece     <= 1'b1;
                        figure_position <= mouse_sq;
                        holding         <= 1'b0;
                        hl_moves        <= '0;
                        if (moves_q[mouse_sq]) begin
                            turn <= ~turn;
                            if (half_moves != {CNT_W{1'b1}})
                                half_moves <= half_moves + CNT_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (white_win || black_win) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        state <= SELECT;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= SELECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_controller.sv
// Directed table-driven bench for move_controller plus hand sequences for
// timeout, game-over and reset corner cases.
module tb_move_controller;

    localparam int T = 8;

    typedef struct packed {
        logic        gs;
        logic        pk;
        logic        pl;
        logic [5:0]  fig;
        logic [5:0]  sel;
        logic        hold;
        logic        turn;
        logic [9:0]  hm;
        logic        go;
        logic [63:0] hl;
    } out_t;

    typedef struct {
        logic        click;
        logic [5:0]  msq;
        logic [3:0]  code;
        logic        gd;
        logic [63:0] mask;
        logic        bw;
        out_t        e;
    } vec_t;

    localparam logic [63:0] M1 = (64'd1 << 44) | (64'd1 << 36);
    localparam logic [63:0] M2 = (64'd1 << 40) | (64'd1 << 42);
    localparam logic [63:0] M3 = (64'd1 << 20);
    localparam logic [63:0] M4 = (64'd1 << 43);

    logic        clk = 1'b0;
    logic        rst;
    logic        click;
    logic [5:0]  mouse_sq;
    logic [3:0]  sq_code;
    logic [63:0] possible_moves;
    logic        gen_done;
    logic        white_win;
    logic        black_win;
    logic        gen_start;
    logic [5:0]  sel_sq;
    logic        pick_piece;
    logic        place_piece;
    logic [5:0]  figure_position;
    logic [63:0] hl_moves;
    logic        turn;
    logic        holding;
    logic        game_over;
    logic [9:0]  half_moves;

    int checks = 0;
    int errors = 0;

    vec_t tv [26];

    move_controller #(.GEN_TIMEOUT(T), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .click(click), .mouse_sq(mouse_sq), .sq_code(sq_code),
        .possible_moves(possible_moves), .gen_done(gen_done),
        .white_win(white_win), .black_win(black_win),
        .gen_start(gen_start), .sel_sq(sel_sq), .pick_piece(pick_piece),
        .place_piece(place_piece), .figure_position(figure_position),
        .hl_moves(hl_moves), .turn(turn), .holding(holding),
        .game_over(game_over), .half_moves(half_moves)
    );

    always #5 clk = ~clk;

    function automatic out_t ex(input logic gs, input logic pk, input logic pl,
                                input logic [5:0] fig, input logic [5:0] sel,
                                input logic hold, input logic trn, input logic [9:0] hm,
                                input logic go, input logic [63:0] hl);
        out_t o;
        o.gs = gs; o.pk = pk; o.pl = pl; o.fig = fig; o.sel = sel;
        o.hold = hold; o.turn = trn; o.hm = hm; o.go = go; o.hl = hl;
        return o;
    endfunction

    function automatic vec_t v(input logic c, input logic [5:0] msq, input logic [3:0] code,
                               input logic gd, input logic [63:0] mask, input logic bw,
                               input out_t e);
        vec_t r;
        r.click = c; r.msq = msq; r.code = code; r.gd = gd; r.mask = mask; r.bw = bw; r.e = e;
        return r;
    endfunction

    task automatic step(input logic c, input logic [5:0] msq, input logic [3:0] code,
                        input logic gd, input logic [63:0] mask, input logic bw);
        click = c; mouse_sq = msq; sq_code = code;
        gen_done = gd; possible_moves = mask; black_win = bw;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input out_t e);
        out_t a;
        a = ex(gen_start, pick_piece, place_piece, figure_position, sel_sq,
               holding, turn, half_moves, game_over, hl_moves);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    initial begin
        rst = 1'b1; click = 1'b0; mouse_sq = '0; sq_code = '0;
        possible_moves = '0; gen_done = 1'b0; white_win = 1'b0; black_win = 1'b0;

        // white pawn 52 -> 36
        tv[0]  = v(1, 6'd52, 4'h1, 0, 64'd0, 0, ex(1,0,0, 6'd0, 6'd52,0,0,10'd0,0,64'd0));
        tv[1]  = v(0, 6'd0,  4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd0, 6'd52,0,0,10'd0,0,64'd0));
        tv[2]  = v(0, 6'd0,  4'h0, 1, M1,    0, ex(0,1,0, 6'd52,6'd52,0,0,10'd0,0,64'd0));
        tv[3]  = v(0, 6'd0,  4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd52,6'd52,1,0,10'd0,0,M1));
        tv[4]  = v(1, 6'd36, 4'h0, 0, 64'd0, 0, ex(0,0,1, 6'd36,6'd52,0,1,10'd1,0,64'd0));
        tv[5]  = v(0, 6'd0,  4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd36,6'd52,0,1,10'd1,0,64'd0));
        tv[6]  = v(0, 6'd0,  4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd36,6'd52,0,1,10'd1,0,64'd0));
        // black pawn 12 -> 20
        tv[7]  = v(1, 6'd12, 4'h7, 0, 64'd0, 0, ex(1,0,0, 6'd36,6'd12,0,1,10'd1,0,64'd0));
        tv[8]  = v(0, 6'd0,  4'h0, 1, M3,    0, ex(0,1,0, 6'd12,6'd12,0,1,10'd1,0,64'd0));
        tv[9]  = v(0, 6'd0,  4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd12,6'd12,1,1,10'd1,0,M3));
        tv[10] = v(1, 6'd20, 4'h0, 0, 64'd0, 0, ex(0,0,1, 6'd20,6'd12,0,0,10'd2,0,64'd0));
        tv[11] = v(0, 6'd0,  4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd20,6'd12,0,0,10'd2,0,64'd0));
        tv[12] = v(0, 6'd0,  4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd20,6'd12,0,0,10'd2,0,64'd0));
        // white to move: black piece, empty and highlight marker are all ignored
        tv[13] = v(1, 6'd10, 4'h7, 0, 64'd0, 0, ex(0,0,0, 6'd20,6'd12,0,0,10'd2,0,64'd0));
        tv[14] = v(1, 6'd11, 4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd20,6'd12,0,0,10'd2,0,64'd0));
        tv[15] = v(1, 6'd11, 4'hD, 0, 64'd0, 0, ex(0,0,0, 6'd20,6'd12,0,0,10'd2,0,64'd0));
        // cancel at 57
        tv[16] = v(1, 6'd57, 4'h2, 0, 64'd0, 0, ex(1,0,0, 6'd20,6'd57,0,0,10'd2,0,64'd0));
        tv[17] = v(0, 6'd0,  4'h0, 1, M2,    0, ex(0,1,0, 6'd57,6'd57,0,0,10'd2,0,64'd0));
        tv[18] = v(0, 6'd0,  4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd57,6'd57,1,0,10'd2,0,M2));
        tv[19] = v(1, 6'd20, 4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd57,6'd57,1,0,10'd2,0,M2));
        tv[20] = v(1, 6'd57, 4'h2, 0, 64'd0, 0, ex(0,0,1, 6'd57,6'd57,0,0,10'd2,0,64'd0));
        tv[21] = v(0, 6'd0,  4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd57,6'd57,0,0,10'd2,0,64'd0));
        tv[22] = v(0, 6'd0,  4'h0, 0, 64'd0, 0, ex(0,0,0, 6'd57,6'd57,0,0,10'd2,0,64'd0));
        // empty mask returns to SELECT
        tv[23] = v(1, 6'd49, 4'h1, 0, 64'd0, 0, ex(1,0,0, 6'd57,6'd49,0,0,10'd2,0,64'd0));
        tv[24] = v(0, 6'd0,  4'h0, 1, 64'd0, 0, ex(0,0,0, 6'd57,6'd49,0,0,10'd2,0,64'd0));
        tv[25] = v(1, 6'd49, 4'h1, 0, 64'd0, 0, ex(1,0,0, 6'd57,6'd49,0,0,10'd2,0,64'd0));

        #12;
        check("reset", ex(0,0,0,6'd0,6'd0,0,0,10'd0,0,64'd0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            step(tv[i].click, tv[i].msq, tv[i].code, tv[i].gd, tv[i].mask, tv[i].bw);
            check($sformatf("vec%0d", i), tv[i].e);
        end

        // timeout: T cycles in GEN with clicks ignored, then SELECT again
        for (int i = 0; i < T; i++) begin
            step(1, 6'd49, 4'h1, 0, 64'd0, 0);
            check($sformatf("timeout_wait%0d", i), ex(0,0,0,6'd57,6'd49,0,0,10'd2,0,64'd0));
        end
        step(1, 6'd51, 4'h1, 0, 64'd0, 0);
        check("after_timeout_select", ex(1,0,0,6'd57,6'd51,0,0,10'd2,0,64'd0));

        // gen_done on the final timeout cycle still wins
        for (int i = 0; i < T - 1; i++) begin
            step(0, 6'd0, 4'h0, 0, 64'd0, 0);
            check($sformatf("gen_wait%0d", i), ex(0,0,0,6'd57,6'd51,0,0,10'd2,0,64'd0));
        end
        step(0, 6'd0, 4'h0, 1, M4, 0);
        check("gen_done_wins", ex(0,1,0,6'd51,6'd51,0,0,10'd2,0,64'd0));
        step(0, 6'd0, 4'h0, 0, 64'd0, 0);
        check("hold_m4", ex(0,0,0,6'd51,6'd51,1,0,10'd2,0,M4));

        // legal drop, board then reports a black win
        step(1, 6'd43, 4'h0, 0, 64'd0, 0);
        check("drop43", ex(0,0,1,6'd43,6'd51,0,1,10'd3,0,64'd0));
        step(0, 6'd0, 4'h0, 0, 64'd0, 1);
        check("place_cycle_done", ex(0,0,0,6'd43,6'd51,0,1,10'd3,0,64'd0));
        step(0, 6'd0, 4'h0, 0, 64'd0, 1);
        check("game_over_set", ex(0,0,0,6'd43,6'd51,0,1,10'd3,1,64'd0));
        for (int i = 0; i < 3; i++) begin
            step(1, 6'd10, 4'h7, 1, M1, 1);
            check($sformatf("over_ignored%0d", i), ex(0,0,0,6'd43,6'd51,0,1,10'd3,1,64'd0));
        end

        // asynchronous reset clears everything
        black_win = 1'b0; click = 1'b0; gen_done = 1'b0;
        rst = 1'b1;
        #2;
        check("mid_reset", ex(0,0,0,6'd0,6'd0,0,0,10'd0,0,64'd0));
        @(negedge clk);
        rst = 1'b0;
        step(1, 6'd52, 4'h1, 0, 64'd0, 0);
        check("post_reset_select", ex(1,0,0,6'd0,6'd52,0,0,10'd0,0,64'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_controller.md
# move_controller

Turn and move sequencer between the mouse front-end, the move generator and `chess_board`. It converts validated square clicks into single-cycle `pick_piece`/`place_piece` pulses with a board address. It enforces side-to-move, requests and latches the legal-move mask, and accepts a drop only on a legal or origin square. It also alternates turns and freezes play once the board reports a win.

## Interface
Parameters:
- `GEN_TIMEOUT`, default 255: cycles to wait for `gen_done` before abandoning a selection.
- `CNT_W`, default 10: width of the half-move counter.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `click` in 1: one-cycle pulse, left button press, already synchronised.
- `mouse_sq` in 6: square under cursor, [5:3] row, [2:0] column; meaningful only with `click`.
- `sq_code` in 4: piece code currently on `mouse_sq`, read combinationally from the board.
- `possible_moves` in 64: legal-target mask from the move generator.
- `gen_done` in 1: one-cycle pulse, `possible_moves` valid.
- `white_win` in 1: board flag.
- `black_win` in 1: board flag.
- `gen_start` out 1: one-cycle request to compute moves for `sel_sq`.
- `sel_sq` out 6: selected origin square.
- `pick_piece` out 1: one-cycle pulse to the board.
- `place_piece` out 1: one-cycle pulse to the board.
- `figure_position` out 6: board address accompanying pick/place.
- `hl_moves` out 64: latched mask while a piece is held, else 0.
- `turn` out 1: 0 = white to move, 1 = black to move.
- `holding` out 1: a piece is lifted.
- `game_over` out 1: sticky.
- `half_moves` out `CNT_W`: completed moves, saturating.

## Operation
- Piece ownership: codes 1–6 are white, 7–C are black; 0 is empty; D is the highlight marker and counts as empty.
- SELECT:
  - A `click` whose `sq_code` belongs to `turn` latches `sel_sq <= mouse_sq`, pulses `gen_start` and goes to GEN.
  - Any other click is ignored.
- GEN:
  - On `gen_done`, latch `possible_moves` into `moves_q`.
  - If `moves_q == 0`, return to SELECT.
  - Otherwise go to PICK.
  - A `GEN_TIMEOUT`-cycle counter expiring with no `gen_done` returns to SELECT.
  - Clicks are ignored in this state.
- PICK: pulse `pick_piece` with `figure_position = sel_sq`, then go to HOLD.
- HOLD: `holding = 1` and `hl_moves = moves_q`. On `click`:
  - If `moves_q[mouse_sq]` is set, this is a legal drop: pulse `place_piece` with `figure_position = mouse_sq`, toggle `turn`, increment `half_moves` (saturating at all-ones), then go to SETTLE.
  - Else if `mouse_sq == sel_sq`, this is a cancel: pulse `place_piece` at `sel_sq`, leave `turn` and the counter unchanged, then go to SETTLE.
  - Otherwise ignore the click and stay in HOLD.
- SETTLE: one cycle. If `white_win | black_win`, set `game_over` and go to OVER; otherwise go to SELECT.
- OVER: absorbing. All clicks are ignored and no pulses are issued. Exit only via `rst`.
- The pick/place pulses are never asserted together and never in consecutive cycles. This keeps the board's internal picked flag consistent.

## Timing
- Reset values:
  - state SELECT
  - `turn` 0, `sel_sq` 0, `moves_q` 0, `hl_moves` 0, `half_moves` 0
  - `holding` 0, `game_over` 0
  - `gen_start`, `pick_piece`, `place_piece` all 0
  - `figure_position` 0
- All outputs are registered.
- `gen_start` rises in the cycle after the accepted click.
- `pick_piece` rises in the cycle after `gen_done` when the mask is non-zero.
- `place_piece` rises in the cycle after the accepted HOLD click.
- `figure_position` is valid in the same cycle as each pulse.
- The board updates its win flags at the edge ending the `place_piece` cycle. SETTLE samples them in the following cycle.
- If `gen_done` and the timeout coincide, `gen_done` wins.
- A `click` in the same cycle as `gen_done` is ignored.
- `rst` mid-HOLD returns to SELECT immediately. The board is reset by the same `rst`, so no piece is lost.

## Structure
- Shared `chess_pkg`:
  - piece code constants (EMPTY, HL=4'hD, W_PAWN..W_KING, B_PAWN..B_KING)
  - function `is_white`/`is_black(code)`
  - `mc_state_t` enum {SELECT, GEN, PICK, HOLD, SETTLE, OVER}
- The timeout counter is inline; no sub-module is needed.

## Test plan
- After reset, click square 52 (`sq_code` 1, white pawn). Expect `gen_start` at +1 cycle. Send `gen_done` with mask bits 44 and 36. Expect `pick_piece` with `figure_position` 52, then `holding` = 1 and `hl_moves` = mask.
- In HOLD, click 36. Expect `place_piece` with `figure_position` 36, `turn` = 1, `half_moves` = 1, then a return to SELECT.
- With `turn` = 0, click a black piece (code 7) and then an empty square. Expect no `gen_start` and the state to remain SELECT.
- Cancel: pick square 57, click 20 (not in mask) and expect nothing; click 57 and expect `place_piece` at 57 with `turn` unchanged.
- Give `gen_done` with mask 0, and separately give no `gen_done` for `GEN_TIMEOUT` cycles. Both must return to SELECT with no `pick_piece`.
- Legal drop with `black_win` forced high in the next cycle: expect `game_over` = 1 and all later clicks ignored; `rst` clears everything.
